encoder_frame_tx: RTL and testbench

// - Encoder-side serial frame transmitter: the far end of the encoder read link. It emulates the absolute encoder for bench and loopback use.
// - It serialises a 19-bit position plus status onto the single-wire miso line, clocked by sck.
// - Line protocol: idle high, one low start bit, then a 24-bit frame MSB first, then at least IDLE_BITS high bits.
// - Frame layout: [23] err, [22] warn, [21:3] position, [2:0] rolling sequence count.

---
 rtl/encoder_frame_tx.sv | 207 ++++++++++++++++++++
 tb/tb_encoder_frame_tx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/encoder_frame_tx.sv
// -----------------------------------------------------------------------------
// encoder_frame_tx
//
// Encoder-side serial frame transmitter. Emulates the far end of the absolute
// encoder read link: a 19-bit position plus err/warn status is serialised onto
// the single-wire miso line, one bit per sck rising edge.
//
// Line format:
//   idle high, one low start bit, FRAME_W data bits MSB first, then at least
//   IDLE_BITS high bits before the next start bit.
//   Frame layout: [FRAME_W-1] err, [FRAME_W-2] warn, [FRAME_W-3:3] position,
//   [2:0] rolling sequence count (the value seq shows once the frame started).
//
// Ports:
//   sck        in   sole clock, all state moves on posedge
//   rst_n      in   asynchronous active-low reset
//   enable     in   1 = new frames may start (a frame in flight always completes)
//   pos_in     in   position to send (DATA_W bits)
//   err_in     in   error flag, latched together with pos_in
//   warn_in    in   warning flag, latched together with pos_in
//   pos_valid  in   pos_in/err_in/warn_in valid; held by the source until taken
//   pos_ready  out  block accepts a frame on the coming edge (decoded from regs)
//   miso       out  serial line, registered
//   busy       out  high from the start bit through the last data bit
//   frame_done out  one-cycle pulse after the last data bit
//   seq        out  sequence value of the most recently started frame
// -----------------------------------------------------------------------------
module encoder_frame_tx #(
    parameter int DATA_W      = 19,
    parameter int IDLE_BITS   = 4,
    parameter bit AUTO_REPEAT = 1'b0
) (
    input  logic              sck,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [DATA_W-1:0] pos_in,
    input  logic              err_in,
    input  logic              warn_in,
    input  logic              pos_valid,
    output logic              pos_ready,
    output logic              miso,
    output logic              busy,
    output logic              frame_done,
    output logic [2:0]        seq
);

    localparam int FRAME_W = DATA_W + 5;
    localparam int CNT_W   = $clog2(FRAME_W);

    // Data bits still to be driven after the MSB has gone out in START.
    localparam logic [CNT_W-1:0] SHIFT_BITS = CNT_W'(FRAME_W - 1);

    // gap_cnt counts high cycles already completed in IDLE. The cycle in
    // which the start edge occurs is itself a high cycle, so a frame may be
    // accepted once IDLE_BITS-1 full cycles have elapsed; this gives a
    // back-to-back period of (FRAME_W + 1) + IDLE_BITS cycles.
    localparam logic [3:0] GAP_MAX   = 4'(IDLE_BITS);
    localparam logic [3:0] GAP_READY = 4'(IDLE_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    state_t             state_r;
    logic [FRAME_W-1:0] frame_r;
    logic [CNT_W-1:0]   bits_left_r;
    logic [3:0]         gap_cnt_r;
    logic [DATA_W-1:0]  pos_lat_r;
    logic               err_lat_r;
    logic               warn_lat_r;
    logic               miso_r;
    logic               busy_r;
    logic               frame_done_r;
    logic [2:0]         seq_r;

    logic               pos_ready_s;
    logic               start_s;
    logic [DATA_W-1:0]  src_pos_s;
    logic               src_err_s;
    logic               src_warn_s;
    logic [2:0]         seq_next_s;

    // Assemble a frame from its fields, MSB first on the wire.
    function automatic logic [FRAME_W-1:0] build_frame(
        input logic              f_err,
        input logic              f_warn,
        input logic [DATA_W-1:0] f_pos,
        input logic [2:0]        f_seq
    );
        return {f_err, f_warn, f_pos, f_seq};
    endfunction

    // Ready decode: idle, gap satisfied and transmission enabled.
    always_comb begin
        pos_ready_s = 1'b0;
        if ((state_r == ST_IDLE) && (gap_cnt_r >= GAP_READY) && enable) begin
            pos_ready_s = 1'b1;
        end else begin
            pos_ready_s = 1'b0;
        end
    end

    // Start decision and payload source: fresh input, or the last latched
    // payload when auto-repeat is enabled and nothing new is offered.
    always_comb begin
        start_s    = 1'b0;
        src_pos_s  = pos_lat_r;
        src_err_s  = err_lat_r;
        src_warn_s = warn_lat_r;
        if (pos_ready_s && pos_valid) begin
            start_s    = 1'b1;
            src_pos_s  = pos_in;
            src_err_s  = err_in;
            src_warn_s = warn_in;
        end else if (pos_ready_s && AUTO_REPEAT) begin
            start_s    = 1'b1;
            src_pos_s  = pos_lat_r;
            src_err_s  = err_lat_r;
            src_warn_s = warn_lat_r;
        end else begin
            start_s    = 1'b0;
            src_pos_s  = pos_lat_r;
            src_err_s  = err_lat_r;
            src_warn_s = warn_lat_r;
        end
    end

    assign seq_next_s = seq_r + 3'd1;

    // Frame FSM: start bit, MSB-first shift-out, stop/gap handling.
    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            frame_r      <= '0;
            bits_left_r  <= '0;
            gap_cnt_r    <= 4'd0;
            pos_lat_r    <= '0;
            err_lat_r    <= 1'b0;
            warn_lat_r   <= 1'b0;
            miso_r       <= 1'b1;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            seq_r        <= 3'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    frame_done_r <= 1'b0;
                    if (start_s) begin
                        pos_lat_r  <= src_pos_s;
                        err_lat_r  <= src_err_s;
                        warn_lat_r <= src_warn_s;
                        frame_r    <= build_frame(src_err_s, src_warn_s, src_pos_s, seq_next_s);
                        seq_r      <= seq_next_s;
                        miso_r     <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= ST_START;
                    end else begin
                        miso_r <= 1'b1;
                        busy_r <= 1'b0;
                        if (gap_cnt_r < GAP_MAX) begin
                            gap_cnt_r <= gap_cnt_r + 4'd1;
                        end else begin
                            gap_cnt_r <= gap_cnt_r;
                        end
                    end
                end
                ST_START: begin
                    miso_r      <= frame_r[FRAME_W-1];
                    frame_r     <= {frame_r[FRAME_W-2:0], 1'b0};
                    bits_left_r <= SHIFT_BITS;
                    state_r     <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (bits_left_r != '0) begin
                        miso_r      <= frame_r[FRAME_W-1];
                        frame_r     <= {frame_r[FRAME_W-2:0], 1'b0};
                        bits_left_r <= bits_left_r - CNT_W'(1);
                    end else begin
                        // All data bits are out: return to idle high and
                        // restart the inter-frame gap from zero.
                        miso_r       <= 1'b1;
                        busy_r       <= 1'b0;
                        frame_done_r <= 1'b1;
                        gap_cnt_r    <= 4'd0;
                        state_r      <= ST_IDLE;
                    end
                end
                default: begin
                    miso_r       <= 1'b1;
                    busy_r       <= 1'b0;
                    frame_done_r <= 1'b0;
                    gap_cnt_r    <= 4'd0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    assign pos_ready  = pos_ready_s;
    assign miso       = miso_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign seq        = seq_r;

endmodule

// File: tb/tb_encoder_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_encoder_frame_tx
//
// Directed bench for encoder_frame_tx. Two instances share the inputs: u_dut
// (AUTO_REPEAT=0) and u_auto (AUTO_REPEAT=1). Outputs are sampled 1 time unit
// after the rising sck edge; a simple receiver model deserialises miso.
// -----------------------------------------------------------------------------
module tb_encoder_frame_tx;

    logic        sck = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [18:0] pos_in;
    logic        err_in;
    logic        warn_in;
    logic        pos_valid;

    logic        pos_ready, miso, busy, frame_done;
    logic [2:0]  seq;
    logic        pos_ready_a, miso_a, busy_a, frame_done_a;
    logic [2:0]  seq_a;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int dut_starts = 0;
    logic busy_q = 1'b0;

    encoder_frame_tx #(.DATA_W(19), .IDLE_BITS(4), .AUTO_REPEAT(1'b0)) u_dut (
        .sck(sck), .rst_n(rst_n), .enable(enable), .pos_in(pos_in),
        .err_in(err_in), .warn_in(warn_in), .pos_valid(pos_valid),
        .pos_ready(pos_ready), .miso(miso), .busy(busy),
        .frame_done(frame_done), .seq(seq)
    );

    encoder_frame_tx #(.DATA_W(19), .IDLE_BITS(4), .AUTO_REPEAT(1'b1)) u_auto (
        .sck(sck), .rst_n(rst_n), .enable(enable), .pos_in(pos_in),
        .err_in(err_in), .warn_in(warn_in), .pos_valid(pos_valid),
        .pos_ready(pos_ready_a), .miso(miso_a), .busy(busy_a),
        .frame_done(frame_done_a), .seq(seq_a)
    );

    always #5 sck = ~sck;

    always @(posedge sck) cyc <= cyc + 1;

    // Count frame starts of u_dut (rising busy), sampled on the falling edge.
    always @(negedge sck) begin
        if (busy === 1'b1 && busy_q === 1'b0) dut_starts++;
        busy_q = busy;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sck);
        #1;
    endtask

    // Step until the selected instance raises busy (start edge), bounded.
    task automatic wait_start(input bit which);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            step();
            if ((which ? busy_a : busy) === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("start_seen", 32'(seen), 32'd1);
    endtask

    // Receive 24 data bits after the start bit, then check the stop edge.
    // drop_at >= 0 lowers enable after that many data bits.
    task automatic rx_frame(input bit which, input int drop_at, output logic [23:0] f);
        f = 24'h0;
        for (int i = 0; i < 24; i++) begin
            step();
            f = {f[22:0], (which ? miso_a : miso)};
            if (i == drop_at) enable = 1'b0;
        end
        step();
        chk("stop_done", 32'(which ? frame_done_a : frame_done), 32'd1);
        chk("stop_busy", 32'(which ? busy_a : busy), 32'd0);
        chk("stop_miso", 32'(which ? miso_a : miso), 32'd1);
    endtask

    initial begin
        logic [23:0] exp_f;
        logic [23:0] got_f;
        logic [18:0] e_pos;
        logic        e_err;
        logic        e_warn;
        logic [2:0]  seq_m;
        int          prev;
        int          base;

        // ---------------- Test 1: reset state and first frame ----------------
        rst_n = 1'b0; enable = 1'b1; pos_valid = 1'b1;
        pos_in = 19'h5A5A5; err_in = 1'b0; warn_in = 1'b1;
        repeat (3) @(posedge sck);
        #1;
        chk("rst_miso", 32'(miso), 32'd1);
        chk("rst_ready", 32'(pos_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_seq", 32'(seq), 32'd0);
        rst_n = 1'b1;
        step(); step();
        chk("gap_ready_early", 32'(pos_ready), 32'd0);
        step();
        chk("gap_ready", 32'(pos_ready), 32'd1);
        step();
        prev = cyc;
        chk("start_miso", 32'(miso), 32'd0);
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_seq", 32'(seq), 32'd1);
        exp_f = {1'b0, 1'b1, 19'h5A5A5, 3'd1};
        for (int k = 0; k < 24; k++) begin
            step();
            chk("bit1", 32'(miso), 32'(exp_f[23-k]));
        end
        chk("busy_last_bit", 32'(busy), 32'd1);
        step();
        chk("f1_done", 32'(frame_done), 32'd1);
        chk("f1_busy", 32'(busy), 32'd0);
        chk("f1_miso", 32'(miso), 32'd1);
        step();
        chk("f1_done_pulse", 32'(frame_done), 32'd0);

        // -------- Test 2: back-to-back with loopback of 50 positions --------
        seq_m = 3'd1;
        for (int f = 0; f < 50; f++) begin
            e_pos = pos_in; e_err = err_in; e_warn = warn_in;
            wait_start(1'b0);
            chk("period", 32'(cyc - prev), 32'd29);
            prev = cyc;
            seq_m = seq_m + 3'd1;
            chk("seq_b2b", 32'(seq), 32'(seq_m));
            // change inputs mid-frame; the frame in flight must not change
            pos_in  = 19'($urandom_range(0, 524287));
            err_in  = 1'($urandom_range(0, 1));
            warn_in = 1'($urandom_range(0, 1));
            rx_frame(1'b0, -1, got_f);
            chk("frame_b2b", 32'(got_f), 32'({e_err, e_warn, e_pos, seq_m}));
            chk("loopback_pos", 32'(got_f[21:3]), 32'(e_pos));
        end

        // ---------------- Test 3: AUTO_REPEAT vs single frame ----------------
        rst_n = 1'b0;
        pos_in = 19'h7FFFF; err_in = 1'b1; warn_in = 1'b0; pos_valid = 1'b1;
        step(); step();
        rst_n = 1'b1;
        base = dut_starts;
        step(); step(); step(); step();
        chk("ar_start_dut", 32'(busy), 32'd1);
        chk("ar_start_auto", 32'(busy_a), 32'd1);
        pos_valid = 1'b0;
        pos_in = 19'h00000;
        prev = cyc;
        seq_m = 3'd1;
        for (int f = 0; f < 4; f++) begin
            if (f > 0) begin
                wait_start(1'b1);
                chk("ar_period", 32'(cyc - prev), 32'd29);
                prev = cyc;
                seq_m = seq_m + 3'd1;
            end
            chk("ar_seq", 32'(seq_a), 32'(seq_m));
            rx_frame(1'b1, -1, got_f);
            chk("ar_frame", 32'(got_f), 32'({1'b1, 1'b0, 19'h7FFFF, seq_m}));
        end
        chk("single_frame_count", 32'(dut_starts - base), 32'd1);
        chk("single_seq", 32'(seq), 32'd1);

        // ---------------- Test 4: enable drop mid-frame ----------------
        pos_in = 19'h12345; err_in = 1'b0; warn_in = 1'b0; pos_valid = 1'b1;
        wait_start(1'b0);
        chk("en_seq", 32'(seq), 32'd2);
        rx_frame(1'b0, 10, got_f);
        chk("en_frame", 32'(got_f), 32'({1'b0, 1'b0, 19'h12345, 3'd2}));
        base = dut_starts;
        repeat (40) step();
        chk("en_ready_low", 32'(pos_ready), 32'd0);
        chk("en_no_start", 32'(dut_starts - base), 32'd0);
        chk("en_idle_miso", 32'(miso), 32'd1);
        enable = 1'b1;
        #1;
        chk("en_ready_back", 32'(pos_ready), 32'd1);
        step();
        chk("en_restart", 32'(busy), 32'd1);
        chk("en_restart_seq", 32'(seq), 32'd3);

        // ---------------- Test 5: reset mid-frame ----------------
        repeat (13) step();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_miso", 32'(miso), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_seq", 32'(seq), 32'd0);
        @(posedge sck);
        #1;
        rst_n = 1'b1;
        step(); step();
        chk("post_rst_ready_early", 32'(pos_ready), 32'd0);
        step();
        chk("post_rst_ready", 32'(pos_ready), 32'd1);
        step();
        chk("post_rst_start", 32'(busy), 32'd1);
        chk("post_rst_seq", 32'(seq), 32'd1);
        rx_frame(1'b0, -1, got_f);
        chk("post_rst_frame", 32'(got_f), 32'({1'b0, 1'b0, 19'h12345, 3'd1}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
